std_fp_mult_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one pipelined fixed-point multiplier (go/done, 3-cycle latency, go held until done) among NUM_REQ requesters.
- Accepts one operand pair at a time and drives the multiplier's go for exactly one operation.
- Returns the product on a shared response channel tagged with the requester index.
- Sits between Calyx-generated control groups and a single std_fp_mult_pipe instance.

---
 rtl/std_fp_mult_arbiter.sv | 140 ++++++++++++++
 tb/tb_std_fp_mult_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_fp_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point multiplier among NUM_REQ requesters.
// Define STD_FP_MULT_ARB_TIMEOUT_EN to add a mul_done watchdog that reports resp_err.
module std_fp_mult_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_left,
    input  logic [NUM_REQ*WIDTH-1:0] req_right,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_err,
    output logic [WIDTH-1:0]         mul_left,
    output logic [WIDTH-1:0]         mul_right,
    output logic                     mul_go,
    input  logic                     mul_done,
    input  logic [WIDTH-1:0]         mul_out
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_n;
    logic [ID_W-1:0] ptr, id_q, gnt, ptr_n;
    logic [ID_W:0]   idx;
    logic            any, take, fin, tmo;

    if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("std_fp_mult_arbiter: inconsistent parameters");
    end

    // first requester at or after ptr, wrapping
    always_comb begin
        any = 1'b0;
        gnt = '0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!any && req_valid[idx[ID_W-1:0]]) begin
                any = 1'b1;
                gnt = idx[ID_W-1:0];
            end
        end
    end

    assign ptr_n = (gnt == ID_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        req_ready  = '0;
        mul_go     = 1'b0;
        resp_valid = 1'b0;
        take       = 1'b0;
        fin        = 1'b0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    req_ready[gnt] = 1'b1;
                    take           = 1'b1;
                    state_n        = BUSY;
                end
            end
            BUSY: begin
                mul_go = 1'b1;
                if (mul_done || tmo) begin
                    fin     = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_left  <= '0;
            mul_right <= '0;
            id_q      <= '0;
            ptr       <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else begin
            if (take) begin
                mul_left  <= req_left[gnt*WIDTH +: WIDTH];
                mul_right <= req_right[gnt*WIDTH +: WIDTH];
                id_q      <= gnt;
                ptr       <= ptr_n;
            end
            if (fin) begin
                resp_data <= tmo ? '0 : mul_out;
                resp_id   <= id_q;
            end
        end
    end

`ifdef STD_FP_MULT_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT+1) > 4) ? $clog2(TIMEOUT+1) : 4;

    logic [TW-1:0] tcnt;
    logic          err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              tcnt <= '0;
        else if (take)           tcnt <= '0;
        else if (state == BUSY)  tcnt <= tcnt + 1'b1;
    end

    // tcnt is 0 in the first BUSY cycle, so this fires at the end of cycle TIMEOUT
    assign tmo = (state == BUSY) && !mul_done && (tcnt == TW'(TIMEOUT-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        err_q <= 1'b0;
        else if (fin)                      err_q <= tmo;
        else if (resp_valid && resp_ready) err_q <= 1'b0;
    end

    assign resp_err = err_q;
`else
    assign tmo      = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_std_fp_mult_arbiter.sv
// Directed bench for std_fp_mult_arbiter with a 16.16 multiplier stand-in.
// Done rises in the 4th consecutive go-high cycle; spur/stuck inject faults.
module tb_std_fp_mult_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_left, req_right;
    logic [N-1:0]   req_ready;
    logic           resp_valid, resp_ready;
    logic [W-1:0]   resp_data;
    logic [IW-1:0]  resp_id;
    logic           resp_err;
    logic [W-1:0]   mul_left, mul_right, mul_out;
    logic           mul_go, mul_done;

    int   n_chk = 0;
    int   n_fail = 0;
    int   gcnt = 0;
    int   c, gap;
    logic stuck = 1'b0;
    logic spur = 1'b0;
    logic [63:0] prod;

    std_fp_mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_left(req_left), .req_right(req_right),
        .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
        .mul_left(mul_left), .mul_right(mul_right), .mul_go(mul_go),
        .mul_done(mul_done), .mul_out(mul_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) gcnt <= mul_go ? gcnt + 1 : 0;

    assign prod     = 64'(mul_left) * 64'(mul_right);
    assign mul_out  = spur ? 32'hdead_beef : prod[47:16];
    assign mul_done = spur | (mul_go && !stuck && gcnt == 3);

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        req_valid  = '0;
        resp_ready = 1'b0;
        spur       = 1'b0;
        stuck      = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    task automatic wait_resp(input int maxc, output int cnt);
        cnt = 0;
        while (resp_valid !== 1'b1 && cnt < maxc) begin
            tick;
            cnt++;
        end
        chk("resp_timeout", 64'(resp_valid), 64'(1));
    endtask

    task automatic set_op(input int i, input logic [31:0] l, input logic [31:0] r);
        req_left[i*W +: W]  = l;
        req_right[i*W +: W] = r;
    endtask

    initial begin
        req_valid  = '0;
        req_left   = '0;
        req_right  = '0;
        resp_ready = 1'b0;

        #12;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_data", 64'(resp_data), 64'(0));
        chk("rst_resp_id", 64'(resp_id), 64'(0));
        chk("rst_resp_err", 64'(resp_err), 64'(0));
        chk("rst_mul_go", 64'(mul_go), 64'(0));
        chk("rst_mul_left", 64'(mul_left), 64'(0));
        chk("rst_mul_right", 64'(mul_right), 64'(0));
        @(posedge clk);
        #3 reset = 1'b1;

        // single op: 2.0 * 1.5
        set_op(0, 32'h0002_0000, 32'h0001_8000);
        resp_ready = 1'b1;
        req_valid  = 4'b0001;
        #1 chk("single_grant", 64'(req_ready), 64'(4'b0001));
        tick;
        req_valid = '0;
        chk("single_go_c1", 64'(mul_go), 64'(1));
        chk("single_left", 64'(mul_left), 64'(32'h0002_0000));
        chk("single_right", 64'(mul_right), 64'(32'h0001_8000));
        chk("busy_no_ready", 64'(req_ready), 64'(0));
        tick;
        chk("single_go_c2", 64'(mul_go), 64'(1));
        tick;
        chk("single_go_c3", 64'(mul_go), 64'(1));
        chk("single_nodone_c3", 64'(mul_done), 64'(0));
        tick;
        chk("single_go_c4", 64'(mul_go), 64'(1));
        chk("single_done_c4", 64'(mul_done), 64'(1));
        chk("single_novalid_c4", 64'(resp_valid), 64'(0));
        tick;
        chk("single_valid_c5", 64'(resp_valid), 64'(1));
        chk("single_data", 64'(resp_data), 64'(32'h0003_0000));
        chk("single_id", 64'(resp_id), 64'(0));
        chk("single_go_c5", 64'(mul_go), 64'(0));
        chk("single_err", 64'(resp_err), 64'(0));
        tick;
        chk("single_drop_c6", 64'(resp_valid), 64'(0));

        // spurious done in IDLE
        spur = 1'b1;
        tick;
        spur = 1'b0;
        chk("spur_idle_valid", 64'(resp_valid), 64'(0));
        chk("spur_idle_go", 64'(mul_go), 64'(0));

        // round robin, all requesting
        do_reset;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 32'(i + 1) << 16, 32'h0002_0000);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                tick;
                chk("rr_gap_go_low", 64'(mul_go), 64'(0));
            end
            wait_resp(12, c);
            gap = c + ((k > 0) ? 1 : 0);
            chk("rr_period", 64'(gap), 64'((k == 0) ? 5 : 6));
            chk("rr_id", 64'(resp_id), 64'(k % 4));
            chk("rr_data", 64'(resp_data), 64'(32'(2 * (k % 4) + 2) << 16));
            chk("rr_resp_go", 64'(mul_go), 64'(0));
        end
        req_valid = '0;
        tick;

        // backpressure
        do_reset;
        req_valid = 4'b1111;
        wait_resp(12, c);
        chk("bp_latency", 64'(c), 64'(5));
        chk("bp_id0", 64'(resp_id), 64'(0));
        for (int j = 0; j < 10; j++) begin
            spur = (j == 3);
            tick;
            chk("bp_valid", 64'(resp_valid), 64'(1));
            chk("bp_data", 64'(resp_data), 64'(32'h0002_0000));
            chk("bp_id", 64'(resp_id), 64'(0));
            chk("bp_go", 64'(mul_go), 64'(0));
            chk("bp_ready", 64'(req_ready), 64'(0));
        end
        spur = 1'b0;
        resp_ready = 1'b1;
        tick;
        chk("bp_next_grant", 64'(req_ready), 64'(4'b0010));
        chk("bp_valid_drop", 64'(resp_valid), 64'(0));
        tick;
        req_valid = '0;
        wait_resp(8, c);
        chk("bp_id1", 64'(resp_id), 64'(1));
        chk("bp_data1", 64'(resp_data), 64'(32'h0004_0000));
        tick;

        // async reset mid-BUSY
        do_reset;
        resp_ready = 1'b1;
        set_op(1, 32'h0005_0000, 32'h0002_0000);
        req_valid = 4'b0010;
        #1 chk("ar_grant1", 64'(req_ready), 64'(4'b0010));
        tick;
        req_valid = '0;
        tick;
        chk("ar_busy_go", 64'(mul_go), 64'(1));
        #1 reset = 1'b0;
        #1;
        chk("ar_go_async", 64'(mul_go), 64'(0));
        chk("ar_left_async", 64'(mul_left), 64'(0));
        chk("ar_right_async", 64'(mul_right), 64'(0));
        chk("ar_ready_async", 64'(req_ready), 64'(0));
        chk("ar_valid_async", 64'(resp_valid), 64'(0));
        @(posedge clk);
        #3 reset = 1'b1;
        req_valid = 4'b0110;
        #1 chk("ar_ptr0", 64'(req_ready), 64'(4'b0010));
        chk("ar_go_low", 64'(mul_go), 64'(0));
        set_op(3, 32'h0003_0000, 32'h0000_8000);
        req_valid = 4'b1000;
        #1 chk("ar_grant3", 64'(req_ready), 64'(4'b1000));
        tick;
        req_valid = '0;
        chk("ar_go3", 64'(mul_go), 64'(1));
        chk("ar_left3", 64'(mul_left), 64'(32'h0003_0000));
        wait_resp(8, c);
        chk("ar_latency3", 64'(c), 64'(4));
        chk("ar_id3", 64'(resp_id), 64'(3));
        chk("ar_data3", 64'(resp_data), 64'(32'h0001_8000));
        tick;

        // wrap and skip: move ptr to 3, then 0101
        set_op(2, 32'h0001_0000, 32'h0001_0000);
        req_valid = 4'b0100;
        #1 chk("ws_pre_grant", 64'(req_ready), 64'(4'b0100));
        tick;
        req_valid = '0;
        wait_resp(8, c);
        chk("ws_pre_id", 64'(resp_id), 64'(2));
        tick;
        set_op(0, 32'h0004_0000, 32'h0004_0000);
        set_op(2, 32'h0000_8000, 32'h0000_8000);
        req_valid = 4'b0101;
        #1 chk("ws_wrap_grant", 64'(req_ready), 64'(4'b0001));
        tick;
        chk("ws_left0", 64'(mul_left), 64'(32'h0004_0000));
        req_valid = 4'b0111;
        tick;
        req_valid = 4'b0101;
        wait_resp(8, c);
        chk("ws_id0", 64'(resp_id), 64'(0));
        chk("ws_data0", 64'(resp_data), 64'(32'h0010_0000));
        tick;
        chk("ws_skip_grant", 64'(req_ready), 64'(4'b0100));
        tick;
        req_valid = '0;
        wait_resp(8, c);
        chk("ws_id2", 64'(resp_id), 64'(2));
        chk("ws_data2", 64'(resp_data), 64'(32'h0000_4000));
        tick;

`ifdef STD_FP_MULT_ARB_TIMEOUT_EN
        do_reset;
        stuck = 1'b1;
        set_op(0, 32'h0002_0000, 32'h0002_0000);
        req_valid = 4'b0001;
        tick;
        req_valid = '0;
        for (int b = 1; b <= 15; b++) begin
            chk("to_busy_go", 64'(mul_go), 64'(1));
            tick;
        end
        chk("to_valid", 64'(resp_valid), 64'(1));
        chk("to_err", 64'(resp_err), 64'(1));
        chk("to_data", 64'(resp_data), 64'(0));
        chk("to_go", 64'(mul_go), 64'(0));
        stuck = 1'b0;
        resp_ready = 1'b1;
        tick;
        chk("to_err_clear", 64'(resp_err), 64'(0));
        req_valid = 4'b0001;
        tick;
        req_valid = '0;
        wait_resp(8, c);
        chk("to_next_err", 64'(resp_err), 64'(0));
        chk("to_next_data", 64'(resp_data), 64'(32'h0004_0000));
        tick;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
